// File: rtl/bcd_pkg.sv
// Shared types, derived widths and helpers for the BCD-to-binary converter.
package bcd_pkg;

    localparam int unsigned DIGITS_DEF = 4;
    localparam int unsigned BIN_W_DEF  = 15;
    localparam int unsigned SW         = 4 * DIGITS_DEF;
    localparam int unsigned CNT_W      = $clog2(SW + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic digit_ok(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

    function automatic int unsigned sw_of(input int unsigned digits);
        return 4 * digits;
    endfunction

    function automatic int unsigned cnt_w_of(input int unsigned digits);
        return $clog2(4 * digits + 1);
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the nibble is >= 8.
module bcd_nibble_adj (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib[3]) begin
            o_nib = i_nib - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_bin_conv.sv
// Sequential BCD-to-binary converter: one reverse double-dabble step per clock,
// start/busy/done handshake, err flags any non-decimal input digit.
module bcd_bin_conv
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned BIN_W  = BIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned SW_L  = sw_of(DIGITS);
    localparam int unsigned CNT_L = cnt_w_of(DIGITS);

    state_t              r_state;
    logic [SW_L-1:0]     r_bcd;
    logic [SW_L-1:0]     r_bin;
    logic [CNT_L-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [BIN_W-1:0]    r_bin_out;

    logic [2*SW_L-1:0]   w_shift;
    logic [SW_L-1:0]     w_bcd_sh;
    logic [SW_L-1:0]     w_bin_sh;
    logic [SW_L-1:0]     w_bcd_adj;
    logic                w_valid;
    logic                w_last;

    assign w_shift  = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_shift[2*SW_L-1:SW_L];
    assign w_bin_sh = w_shift[SW_L-1:0];
    assign w_last   = (r_cnt == CNT_L'(SW_L - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .i_nib (w_bcd_sh[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        w_valid = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!digit_ok(bcd_in[4*i +: 4])) begin
                w_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bin_out <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd  <= bcd_in;
                        r_bin  <= '0;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (w_valid) begin
                            r_state <= SHIFT;
                        end else begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_err     <= 1'b1;
                            r_bin_out <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + CNT_L'(1);
                    if (w_last) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        // Upper bits are provably zero given the BIN_W sizing rule.
                        r_bin_out <= BIN_W'(w_bin_sh);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign bin_out = r_bin_out;

endmodule

// File: tb/tb_bcd_bin_conv.sv
// Directed self-checking bench for bcd_bin_conv: latency, extremes, invalid digits,
// ignored starts, asynchronous reset and a sampled BCD round trip.
module tb_bcd_bin_conv;
    import bcd_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [14:0] bin_out;
    logic        err;

    int n_tests;
    int n_fail;

    bcd_bin_conv #(
        .DIGITS (4),
        .BIN_W  (15)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drives one conversion and reports what was seen; callers do the comparisons.
    task automatic do_conv(input logic [15:0] bcd, output int lat, output logic [14:0] b,
                           output logic e, output logic busy_seen, output logic pulse_ok);
        @(posedge clk); #1;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk); #1;
        start     = 1'b0;
        busy_seen = busy;
        lat       = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        b = bin_out;
        e = err;
        @(posedge clk); #1;
        pulse_ok = !done && !busy;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, err, bin_out} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b err=%b bin_out=%h, required all 0",
                     busy, done, err, bin_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_convert(input logic [15:0] bcd, input logic [14:0] exp_bin,
                                input string name);
        int lat; logic [14:0] b; logic e, bs, pk;
        do_conv(bcd, lat, b, e, bs, pk);
        n_tests++;
        if (lat !== int'(SW) || b !== exp_bin || e !== 1'b0 || bs !== 1'b1 || pk !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: lat=%0d bin=%0d err=%b busy=%b pulse_ok=%b, required lat=%0d bin=%0d err=0 busy=1 pulse_ok=1",
                     name, lat, b, e, bs, pk, SW, exp_bin);
        end
    endtask

    task automatic test_invalid();
        int lat; logic [14:0] b; logic e, bs, pk;
        do_conv(16'h12A4, lat, b, e, bs, pk);
        n_tests++;
        if (lat !== 0 || b !== 15'd0 || e !== 1'b1 || bs !== 1'b1 || pk !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_digit: lat=%0d bin=%0d err=%b busy=%b pulse_ok=%b, required lat=0 bin=0 err=1 busy=1 pulse_ok=1",
                     lat, b, e, bs, pk);
        end
    endtask

    task automatic test_start_ignored();
        int dones; logic [14:0] seen;
        dones = 0;
        seen  = '0;
        @(posedge clk); #1;
        start  = 1'b1;
        bcd_in = 16'h0042;
        @(posedge clk); #1;
        bcd_in = 16'h9999;
        // i counts edges after the accept edge; i==5 is mid-shift, i==16 is the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            start = (i == 5) || (i == int'(SW));
            @(posedge clk); #1;
            if (done) begin
                dones++;
                seen = bin_out;
            end
        end
        start = 1'b0;
        n_tests++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL ignore_start_count: dones=%0d, required 1", dones);
        end
        n_tests++;
        if (seen !== 15'd42) begin
            n_fail++;
            $display("FAIL ignore_start_value: bin=%0d, required 42", seen);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(posedge clk); #1;
        start  = 1'b1;
        bcd_in = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, err, bin_out} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy=%b done=%b err=%b bin_out=%h, required all 0",
                     busy, done, err, bin_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: dones=%0d, required 0", dones);
        end
        test_convert(16'h1234, 15'd1234, "after_reset_1234");
    endtask

    task automatic test_round_trip();
        int lat; logic [14:0] b; logic e, bs, pk;
        for (int v = 0; v < 10000; v += 97) begin
            do_conv(to_bcd(v), lat, b, e, bs, pk);
            n_tests++;
            if (b !== 15'(v) || e !== 1'b0) begin
                n_fail++;
                $display("FAIL round_trip: v=%0d bin=%0d err=%b, required bin=%0d err=0",
                         v, b, e, v);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_convert(16'h2000, 15'h07D0, "nominal_2000");
        test_convert(16'h9999, 15'h270F, "max_9999");
        test_convert(16'h0000, 15'd0, "zero");
        test_convert(16'h0001, 15'd1, "one");
        test_convert(16'h0808, 15'd808, "nibble_8s");
        test_invalid();
        test_convert(16'h0042, 15'd42, "after_invalid_42");
        test_start_ignored();
        test_reset_mid();
        test_round_trip();
        test_convert(16'h9999, 15'd9999, "final_9999");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
